// File: rtl/stream_mux.sv
// stream_mux: N-input, W-bit packet multiplexer with valid/ready handshakes.
// Grants one input for a whole packet (through its last beat). The grant
// comes either from a fixed select or from a round-robin search. The output
// stage is registered.
//
// Ports:
//   clock        rising-edge clock
//   reset_n      synchronous active-low reset
//   mode         0 = fixed select, 1 = round-robin
//   select       channel index used in fixed mode (out-of-range never grants)
//   in_data      channel i at [i*WIDTH +: WIDTH]
//   in_valid     per-channel beat valid
//   in_last      per-channel last beat of packet
//   in_ready     per-channel accept (combinational from out_ready)
//   out_data     registered data
//   out_valid    registered valid
//   out_last     registered last flag
//   out_channel  source channel of the current output beat
//   out_ready    downstream accept
//
// Constraints: NUM_INPUTS >= 2, SEL_W >= clog2(NUM_INPUTS).
module stream_mux #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned NUM_INPUTS = 4,
    parameter int unsigned SEL_W      = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        mode,
    input  logic [SEL_W-1:0]            select,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic [NUM_INPUTS-1:0]       in_valid,
    input  logic [NUM_INPUTS-1:0]       in_last,
    output logic [NUM_INPUTS-1:0]       in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_valid,
    output logic                        out_last,
    output logic [SEL_W-1:0]            out_channel,
    input  logic                        out_ready
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   grant;
    logic [SEL_W-1:0]   rr_ptr;

    logic               cand_found;
    logic [SEL_W-1:0]   cand_idx;
    logic               g_valid;
    logic               g_last;
    logic [WIDTH-1:0]   g_data;
    logic               out_free;
    logic               xfer;

    // Arbitration candidate. In round-robin mode the search runs from the
    // farthest offset down to rr_ptr+1, so the last hit is the nearest
    // valid channel after rr_ptr (the just-completed channel ranks last).
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        if (!mode) begin
            for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                if (select == SEL_W'(i) && in_valid[i]) begin
                    cand_found = 1'b1;
                    cand_idx   = SEL_W'(i);
                end
            end
        end else begin
            for (int unsigned k = NUM_INPUTS; k >= 1; k--) begin
                for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
                    if (i == (32'(rr_ptr) + k) % NUM_INPUTS && in_valid[i]) begin
                        cand_found = 1'b1;
                        cand_idx   = SEL_W'(i);
                    end
                end
            end
        end
    end

    // Signals of the currently granted channel.
    always_comb begin
        g_valid = 1'b0;
        g_last  = 1'b0;
        g_data  = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            if (grant == SEL_W'(i)) begin
                g_valid = in_valid[i];
                g_last  = in_last[i];
                g_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // The output register can take a beat when empty or being popped.
    assign out_free = ~out_valid | out_ready;
    assign xfer     = (state == LOCKED) & g_valid & out_free;

    always_comb begin
        in_ready = '0;
        for (int unsigned i = 0; i < NUM_INPUTS; i++) begin
            in_ready[i] = (state == LOCKED) && (grant == SEL_W'(i)) && out_free;
        end
    end

    // FSM, round-robin pointer and output register.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            grant       <= '0;
            rr_ptr      <= SEL_W'(NUM_INPUTS - 1);
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            out_channel <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand_found) begin
                        grant <= cand_idx;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (xfer && g_last) begin
                        rr_ptr <= grant;
                        state  <= IDLE;
                    end
                end
            endcase

            if (xfer) begin
                out_data    <= g_data;
                out_last    <= g_last;
                out_channel <= grant;
                out_valid   <= 1'b1;
            end else if (out_ready) begin
                out_valid   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// Scoreboard bench for stream_mux (NUM_INPUTS=4, WIDTH=8, SEL_W=3).
module tb_stream_mux;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NIN   = 4;
    localparam int unsigned SW    = 3;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] ch;
    } beat_t;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  mode;
    logic [SW-1:0]         select;
    logic [NIN*WIDTH-1:0]  in_data;
    logic [NIN-1:0]        in_valid;
    logic [NIN-1:0]        in_last;
    logic [NIN-1:0]        in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_last;
    logic [SW-1:0]         out_channel;
    logic                  out_ready;

    beat_t exp_q[$];
    beat_t mon_exp;
    int    n_cmp = 0;
    int    n_err = 0;

    stream_mux #(.WIDTH(WIDTH), .NUM_INPUTS(NIN), .SEL_W(SW)) dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .mode       (mode),
        .select     (select),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .out_channel(out_channel),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: got timeout, expected handshake", name);
    endtask

    // Monitor: every accepted output beat is compared with the scoreboard head.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL out_beat: got unexpected beat 0x%0h ch %0d, expected none",
                         out_data, out_channel);
            end else begin
                mon_exp = exp_q.pop_front();
                check("out_beat", 32'({out_data, out_last, out_channel}), 32'(mon_exp));
            end
        end
    end

    // Wait for a handshake on channel ch; returns with the beat accepted.
    task automatic wait_hs(input int ch, output int waits);
        waits = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_valid[ch] && in_ready[ch]) begin
                @(posedge clk);
                #1;
                return;
            end
            waits++;
        end
        fail("hs_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [7:0] d, input logic l, input int ch);
        beat_t b;
        b.data = d;
        b.last = l;
        b.ch   = 3'(ch);
        exp_q.push_back(b);
    endtask

    // Send an n-beat packet base, base+1, ... on channel ch.
    task automatic send_packet(input int ch, input int n, input logic [7:0] base,
                               output int stalls);
        int w;
        stalls = 0;
        for (int b = 0; b < n; b++) push_exp(base + 8'(b), (b == n - 1), ch);
        for (int b = 0; b < n; b++) begin
            in_data[ch*8 +: 8] = base + 8'(b);
            in_last[ch]        = (b == n - 1);
            in_valid[ch]       = 1'b1;
            wait_hs(ch, w);
            if (b > 0) stalls += w;
        end
        in_valid[ch] = 1'b0;
        in_last[ch]  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        int st, st2, w, cyc, last_cyc, hs;

        // Reset with every channel requesting.
        reset_n   = 1'b0;
        mode      = 1'b1;
        select    = '0;
        out_ready = 1'b1;
        in_valid  = 4'hF;
        in_last   = 4'hF;
        in_data   = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_out_data",  32'(out_data),  32'h00);
            check("rst_in_ready",  32'(in_ready),  32'h0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Round-robin over single-beat packets: 0,1,2,3,0 with one bubble each.
        push_exp(8'hC0, 1'b1, 0);
        push_exp(8'hC1, 1'b1, 1);
        push_exp(8'hC2, 1'b1, 2);
        push_exp(8'hC3, 1'b1, 3);
        push_exp(8'hC0, 1'b1, 0);
        cyc = 0; last_cyc = 0; hs = 0;
        for (int i = 0; i < 100 && hs < 5; i++) begin
            @(negedge clk);
            cyc++;
            if ((in_ready & in_valid) != 4'h0) begin
                hs++;
                if (hs > 1) check("rr_gap", 32'(cyc - last_cyc), 32'd2);
                last_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (hs == 5) begin
                in_valid = 4'h0;
                in_last  = 4'h0;
            end
        end
        if (hs != 5) fail("rr_timeout");

        // Fixed select on channel 2 while the others request too.
        mode   = 1'b0;
        select = 3'd2;
        in_data  = {8'hE3, 8'h00, 8'hE1, 8'hE0};
        in_valid = 4'b1011;
        in_last  = 4'b1011;
        fork
            begin
                send_packet(2, 3, 8'hA1, st);
                check("fix_stalls", 32'(st), 32'd0);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check("fix_others_ready", 32'(in_ready & 4'b1011), 32'h0);
                end
            end
        join
        in_valid = 4'h0;
        in_last  = 4'h0;

        // Backpressure mid-packet on channel 1.
        select = 3'd1;
        fork
            begin
                send_packet(1, 3, 8'h10, st);
                check("bp_stalls", 32'(st), 32'd3);
            end
            begin
                for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    check("bp_data_frozen", 32'(out_data), 32'h10);
                    check("bp_valid_held",  32'(out_valid), 32'd1);
                    check("bp_ready1_low",  32'(in_ready[1]), 32'd0);
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join

        // Select moves to 3 while locked on channel 1; channel 1 finishes first.
        select = 3'd1;
        fork
            send_packet(1, 3, 8'h20, st);
            begin
                repeat (3) @(posedge clk);
                #1;
                select = 3'd3;
                send_packet(3, 1, 8'h33, st2);
            end
        join

        // Out-of-range select never grants.
        repeat (2) @(posedge clk);
        #1;
        select   = 3'd5;
        in_data  = {8'hF3, 8'hF2, 8'hF1, 8'hF0};
        in_valid = 4'hF;
        in_last  = 4'hF;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("oor_in_ready",  32'(in_ready),  32'h0);
            check("oor_out_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 4'h0;
        in_last  = 4'h0;

        // Channel 1 completes so the round-robin pointer moves to 1.
        mode = 1'b1;
        send_packet(1, 1, 8'h30, st);

        // Reset after beat 2 of a 4-beat packet on channel 2.
        push_exp(8'h40, 1'b0, 2);
        in_data[2*8 +: 8] = 8'h40;
        in_last[2]        = 1'b0;
        in_valid[2]       = 1'b1;
        wait_hs(2, w);
        in_data[2*8 +: 8] = 8'h41;
        wait_hs(2, w);
        out_ready   = 1'b0;
        reset_n     = 1'b0;
        in_valid[2] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready",  32'(in_ready),  32'h0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;

        // Fresh round-robin after reset starts at channel 0 again.
        push_exp(8'h50, 1'b1, 0);
        push_exp(8'h52, 1'b1, 2);
        in_data  = {8'h00, 8'h52, 8'h00, 8'h50};
        in_last  = 4'b0101;
        in_valid = 4'b0101;
        wait_hs(0, w);
        in_valid[0] = 1'b0;
        wait_hs(2, w);
        in_valid = 4'h0;
        in_last  = 4'h0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
Name: stream_mux

Overview:
- Parametrised successor to the team's 4:1 single-bit multiplexer.
- N-input, W-bit packet multiplexer with a valid/ready handshake on every input and on the output, plus a registered output stage.
- Operates in fixed-select or round-robin mode. A grant is held for a whole packet, up to and including the in_last beat.
- Sits between the per-unit result streams and the shared writeback/bus path.

Parameters:
- WIDTH, 8: data width per channel in bits.
- NUM_INPUTS, 4: number of input channels; must be 2 or more.
- SEL_W, 2: width of select and out_channel; must be at least clog2(NUM_INPUTS).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  synchronous, active-low reset.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used when mode = 0.
- in_data  input  NUM_INPUTS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_INPUTS  per-channel beat valid.
- in_last  input  NUM_INPUTS  per-channel last beat of packet.
- in_ready  output  NUM_INPUTS  per-channel beat accepted when in_valid[i] & in_ready[i].
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_last  output  1  registered last flag.
- out_channel  output  SEL_W  source channel of the current output beat.
- out_ready  input  1  downstream accept.

Behaviour:
- One clock domain. Reset is synchronous and active-low: it takes effect only on a rising clock edge with reset_n = 0.
- Values under reset:
  - state = IDLE, grant = 0.
  - rr_ptr = NUM_INPUTS-1, so the first round-robin search starts at channel 0.
  - out_valid = 0, out_data = 0, out_last = 0, out_channel = 0, in_ready = all 0.
- State IDLE:
  - in_ready is all 0.
  - Arbitration is evaluated every cycle:
    - mode = 0: candidate = select, but only if select < NUM_INPUTS and in_valid[select] = 1.
    - mode = 1: candidate = the first channel with in_valid set, searching rr_ptr+1, rr_ptr+2, ... modulo NUM_INPUTS.
  - If a candidate exists: grant <= candidate and go to LOCKED on the next edge. Otherwise stay in IDLE.
  - An out-of-range select never grants; the block stays in IDLE with no error flag.
- State LOCKED:
  - in_ready[grant] = ~out_valid | out_ready. Every other in_ready bit is 0. This ready is combinational from out_ready.
  - A transfer (in_valid[grant] & in_ready[grant]) loads out_data, out_last and out_channel = grant, and sets out_valid = 1.
  - A transfer with in_last[grant] = 1 sets rr_ptr <= grant and returns to IDLE.
  - mode and select are ignored while in LOCKED. They are sampled again only in IDLE.
- Output register:
  - out_valid & out_ready with no new transfer clears out_valid.
  - A simultaneous pop and new transfer keeps out_valid = 1 and loads the new beat.
  - While out_valid & ~out_ready, out_data, out_last and out_channel are held stable.
- Latency and throughput:
  - in_valid rising in IDLE gives in_ready at cycle +1 at the earliest, and out_valid at cycle +2.
  - Streaming rate is one beat per cycle while LOCKED and out_ready = 1.
  - There is a mandatory one-cycle IDLE bubble between packets.
- Round-robin fairness: the most recently completed channel has the lowest priority in the next arbitration.
- Single-beat packet: a beat with in_last = 1 on the first transfer behaves identically to a multi-beat packet: LOCKED for that beat, then IDLE.
- Reset mid-packet: the in-flight output beat is dropped (out_valid = 0), the grant is released and rr_ptr is restored. No partial state survives.
- in_valid of a non-granted channel has no effect while LOCKED.

Test Plan:
- Reset: hold reset_n = 0 for 2 cycles with all in_valid = 1 -> out_valid = 0, out_data = 0x00, in_ready = 4'b0000 throughout. The first grant in mode 1 after release goes to channel 0.
- Fixed select: mode = 0, select = 2, channel 2 sends 3 beats 0xA1, 0xA2, 0xA3 (last on 0xA3), out_ready = 1 -> out_data 0xA1..0xA3 on consecutive cycles, out_channel = 2, out_last only with 0xA3. Channels 0, 1 and 3 valid but in_ready stays 0.
- Round-robin: mode = 1, all channels continuously send 1-beat packets -> grant order 0, 1, 2, 3, 0, with exactly one IDLE bubble cycle between grants.
- Backpressure: stream 0x10, 0x11, 0x12 from channel 1 with out_ready = 0 for 3 cycles mid-packet -> out_data frozen at 0x10 and in_ready[1] = 0 during the stall. After release the data arrive in order with no loss or duplication.
- Lock and out of range: mode = 0, select = 3 while LOCKED on channel 1 -> channel 1 finishes its packet first. Then select = 5 with NUM_INPUTS = 4 and SEL_W = 3 -> stays in IDLE, no transfer.
- Reset mid-packet: assert reset_n = 0 after beat 2 of a 4-beat packet -> out_valid = 0 on the next edge. After release, a fresh arbitration selects channel 0 in mode 1.
